// File: rtl/swiglu_gate_mul.sv
// Streaming SwiGLU gate multiplier: joins the SiLU (A) and up-projection (B) streams and emits the
// rounded element-wise product through a 2-stage backpressured pipeline. Optional: SWIGLU_GATE_SAT_EN.
module swiglu_gate_mul #(
  parameter int DIM       = 1,
  parameter int WIDTH     = 16,
  parameter int FRAC      = 8,
  parameter int VEC_BEATS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [DIM*WIDTH-1:0] a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [DIM*WIDTH-1:0] b_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM*WIDTH-1:0] out_data,
  output logic                 out_last
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1;
  localparam logic [PW:0] RND = (PW+1)'((FRAC > 0) ? (2 ** (FRAC - 1)) : 0);

  logic                 s1_valid;
  logic                 s1_last;
  logic signed [PW-1:0] s1_prod [DIM];
  logic [CW-1:0]        beat_cnt;
  logic [DIM*WIDTH-1:0] rounded;
  logic                 s1_rdy;
  logic                 s2_rdy;
  logic                 fire;
  logic                 cnt_at_last;

  // Stage 2 is out_valid/out_data/out_last; a full stage frees up when its consumer takes it.
  assign s2_rdy      = !out_valid | out_ready;
  assign s1_rdy      = !s1_valid | s2_rdy;
  assign fire        = a_valid & b_valid & s1_rdy;
  assign a_ready     = b_valid & s1_rdy;
  assign b_ready     = a_valid & s1_rdy;
  assign cnt_at_last = (beat_cnt == CW'(VEC_BEATS - 1));

  // Round half away from zero on the magnitude, then restore the sign and fit to WIDTH.
  function automatic logic [WIDTH-1:0] round_lane(input logic signed [PW-1:0] p);
    // NOTE: function locals are plain temporaries, so blocking assignment is correct here;
    // registered state below always uses non-blocking assignment.
    logic [PW:0]          mag;
    logic [PW:0]          q;
    logic signed [PW+1:0] r;
`ifdef SWIGLU_GATE_SAT_EN
    logic signed [PW+1:0] smax;
    logic signed [PW+1:0] smin;
`endif
    mag = p[PW-1] ? ({1'b0, ~p} + (PW+1)'(1)) : {1'b0, p};
    q   = (mag + RND) >> FRAC;
    r   = p[PW-1] ? -$signed({1'b0, q}) : $signed({1'b0, q});
`ifdef SWIGLU_GATE_SAT_EN
    smax = $signed({{(PW+3-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}});
    smin = ~smax;
    if (r > smax)      round_lane = smax[WIDTH-1:0];
    else if (r < smin) round_lane = smin[WIDTH-1:0];
    else               round_lane = r[WIDTH-1:0];
`else
    round_lane = r[WIDTH-1:0];
`endif
  endfunction

  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    rounded = '0;
    for (int j = 0; j < DIM; j++) begin
      rounded[j*WIDTH +: WIDTH] = round_lane(s1_prod[j]);
    end
  end

  // NOTE: stage-1 product registers carry no reset; s1_valid qualifies them, so leaving the wide
  // datapath unreset is safe and keeps the reset net small.
  always_ff @(posedge clk) begin
    if (fire) begin
      for (int j = 0; j < DIM; j++) begin
        s1_prod[j] <= $signed(a_data[j*WIDTH +: WIDTH]) * $signed(b_data[j*WIDTH +: WIDTH]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (s1_rdy) begin
        s1_valid <= fire;
      end
      if (fire) begin
        s1_last  <= cnt_at_last;
        beat_cnt <= cnt_at_last ? '0 : beat_cnt + CW'(1);
      end
      // A stalled stage 2 holds its beat; when it drains, the same edge refills it from stage 1.
      if (s2_rdy) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= rounded;
          out_last <= s1_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_swiglu_gate_mul.sv
// Self-checking bench for swiglu_gate_mul (Q8.8, DIM=1, VEC_BEATS=4, default wrap-around build).
module tb_swiglu_gate_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, out_ready;
  logic        a_ready, b_ready, out_valid, out_last;
  logic [15:0] a_data, b_data, out_data;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [15:0] data; logic last; } beat_t;
  beat_t exp_q[$];
  int    model_idx = 0;
  int    n_fire    = 0;
  int    n_out     = 0;
  logic  last_log [256];

  logic        stall_prev = 1'b0;
  logic [15:0] held_data;
  logic        held_last;

  always #5 clk = ~clk;

  swiglu_gate_mul #(.DIM(1), .WIDTH(16), .FRAC(8), .VEC_BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact integer product, round half away from zero, keep low 16 bits.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int p, m, r;
    p = $signed(a) * $signed(b);
    m = (p < 0) ? -p : p;
    r = (m + 128) / 256;
    if (p < 0) r = -r;
    return r[15:0];
  endfunction

  // Scoreboard: every accepted pair queues its expected result; every output handshake pops one.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_idx  = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", {31'd0, out_valid}, 32'd1);
        check("stall_data_held", {16'd0, out_data}, {16'd0, held_data});
        check("stall_last_held", {31'd0, out_last}, {31'd0, held_last});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", {16'd0, out_data}, {16'd0, e.data});
          check("out_last", {31'd0, out_last}, {31'd0, e.last});
        end
        if (n_out < 256) last_log[n_out] = out_last;
        n_out++;
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
      if (a_valid && a_ready && b_valid && b_ready) begin
        exp_q.push_back('{data: ref_mul(a_data, b_data), last: (model_idx == 3)});
        model_idx = (model_idx + 1) % 4;
        n_fire++;
      end
    end
  end

  // Offer one pair; returns #1 after the edge that accepted it.
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int   cyc = 0;
    logic acc;
    a_valid = 1'b1; b_valid = 1'b1; a_data = a; b_data = b;
    do begin
      @(negedge clk);
      acc = a_ready && b_ready;
      @(posedge clk); #1;
      cyc++;
    end while (!acc && cyc < 100);
    if (!acc) check("send_timeout", 32'd1, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_timeout", {31'd0, (cyc >= 100)}, 32'd0);
  endtask

  logic [15:0] t4_a [4] = '{16'h0100, 16'h0180, 16'hFF00, 16'h0040};
  logic [15:0] t4_b [4] = '{16'h0300, 16'h0200, 16'h0100, 16'hFFC0};

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    a_data = '0; b_data = '0;

    // Hand-computed anchors for the reference arithmetic itself.
    check("ref_1x2", {16'd0, ref_mul(16'h0100, 16'h0200)}, 32'h0200);
    check("ref_half_pos", {16'd0, ref_mul(16'h0080, 16'h0001)}, 32'h0001);
    check("ref_half_neg", {16'd0, ref_mul(16'hFF80, 16'h0001)}, 32'hFFFF);
    check("ref_wrap", {16'd0, ref_mul(16'h7FFF, 16'h0200)}, 32'hFFFE);

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: 1.0 * 2.0, latency exactly 2 cycles.
    send(16'h0100, 16'h0200);
    @(negedge clk);
    check("t1_not_yet_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("t1_valid_at_2", {31'd0, out_valid}, 32'd1);
    check("t1_data", {16'd0, out_data}, 32'h0200);
    drain();

    // T2: half-LSB products round away from zero.
    send(16'h0080, 16'h0001);
    send(16'hFF80, 16'h0001);
    drain();

    // T3: overflow wraps in the default build.
    send(16'h7FFF, 16'h0200);
    @(negedge clk); @(negedge clk);
    check("t3_wrap", {16'd0, out_data}, 32'hFFFE);
    drain();

    // T4: a_valid held, b_valid toggling; a_ready must follow b_valid.
    begin
      int k = 0;
      for (int i = 0; i < 8; i++) begin
        a_valid = 1'b1; b_valid = (i % 2 == 0);
        a_data = t4_a[k % 4]; b_data = t4_b[k % 4];
        @(negedge clk);
        check("t4_a_ready_eq_b_valid", {31'd0, a_ready}, {31'd0, b_valid});
        if (a_ready && b_ready) k++;
        @(posedge clk); #1;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      check("t4_pairs_taken", k, 32'd4);
    end
    drain();

    // T5: 8 beats, out_ready low at first; capacity 2, then everything drains in order.
    begin
      int base_fire, base_out;
      base_fire = n_fire;
      base_out  = n_out;
      out_ready = 1'b0;
      fork
        for (int i = 0; i < 8; i++) send(16'(16'h0100 + 16'(i * 16'h0040)), 16'h0180);
        begin
          repeat (5) @(posedge clk);
          @(negedge clk);
          check("t5_capacity", n_fire - base_fire, 32'd2);
          check("t5_a_ready_low", {31'd0, a_ready}, 32'd0);
          @(posedge clk); #1;
          out_ready = 1'b1;
        end
      join
      drain();
      check("t5_out_count", n_out - base_out, 32'd8);
      check("t5_last_beat4", {31'd0, last_log[base_out + 3]}, 32'd1);
      check("t5_last_beat8", {31'd0, last_log[base_out + 7]}, 32'd1);
      check("t5_not_last_beat1", {31'd0, last_log[base_out]}, 32'd0);
    end

    // T6: reset with 2 beats in flight, then a fresh row starts at beat index 0.
    out_ready = 1'b0;
    send(16'h0200, 16'h0200);
    send(16'h0300, 16'h0100);
    @(negedge clk);
    check("t6_inflight_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    begin
      int base_out;
      base_out = n_out;
      for (int i = 0; i < 4; i++) send(16'h0100, 16'(16'h0010 * (i + 1)));
      drain();
      check("t6_out_count", n_out - base_out, 32'd4);
      check("t6_first_not_last", {31'd0, last_log[base_out]}, 32'd0);
      check("t6_fourth_last", {31'd0, last_log[base_out + 3]}, 32'd1);
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
